addr_dec_sched: RTL and testbench
=================================

// Module: addr_dec_sched
// PURPOSE
//  Shares one registered 2-of-5 address decoder among NREQ requesters (device/channel logic).
//  Each requester presents a 12-bit address: hundreds (2b binary), tens (2-of-5), units (2-of-5).
//  Round-robin grant, code check, decode to binary 0..399, then result handed downstream on valid/ready.
//  Counts malformed addresses for the diagnostic status register.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  SRCW   2  width of o_src, = $clog2(NREQ)
// PORTS
//  i_clk      in   1          clock; the block runs on this single clock
//  i_rst_n    in   1          reset, asynchronous assert, active low
//  i_req      in   NREQ       level request; held until matching o_gnt bit
//  i_addr     in   12*NREQ    slice k = [12k+11:12k]: [11:10] hundreds, [9:5] tens a..e, [4:0] units a..e
//  o_gnt      out  NREQ       one-hot, 1-cycle pulse; slice captured in that cycle
//  o_valid    out  1          result valid
//  i_rdy      in   1          downstream accepts when o_valid & i_rdy
//  o_bin      out  9          binary address, h*100 + t*10 + u
//  o_src      out  SRCW       requester index of the result
//  o_err      out  1          tens or units field not exactly two bits set
//  o_err_cnt  out  8          saturating count of results with o_err=1
// BEHAVIOUR
//  Reset: o_gnt=0, o_valid=0, o_bin=0, o_src=0, o_err=0, o_err_cnt=0.
//    s1_valid=0. RR pointer last=NREQ-1, so req0 wins first.
//  Stage 1 (capture): grant allowed when !s1_valid | s1_adv.
//    s1_adv = s1_valid & (!o_valid | i_rdy).
//    The winner's slice and index are latched; s1_valid is set; last=winner.
//  Round robin: search from last+1 upward, modulo NREQ. If no request is pending, no grant and s1_valid clears on advance.
//  Stage 2 (output): on s1_adv, load o_bin/o_src/o_err and set o_valid.
//    o_valid clears on accept if there is no s1_adv that cycle.
//  Latency: o_gnt in cycle N -> o_valid in N+1 (no stall). Throughput is 1 result per cycle.
//  Stall: o_valid & !i_rdy holds all outputs stable. s1 holds. No grant while s1 is full.
//  Digit map (pair of set bits -> value): ab=4 ac=5 ad=1 ae=2 bc=6 bd=7 be=3 cd=8 ce=9 de=0.
//  Illegal digit (0, 1, 3+ bits set): o_err=1, o_bin=0, o_valid still asserted normally.
//  o_err_cnt increments on each accepted result with o_err=1; it saturates at 255.
//  Arithmetic: 9-bit unsigned, h*100 + t*10 + u; max 399, no truncation.
//  Requester deasserting i_req before grant: legal, no grant issued.
//  Reset mid-operation: in-flight result is dropped. Requesters must hold i_req; they are re-arbitrated after reset.
// STRUCTURE
//  Package addr_dec_pkg: ADDR_W=12, BIN_W=9, field LSB constants (H=10, T=5, U=0),
//    localparam digit code constants, HUND_WT=100, TENS_WT=10.
//  Sub-module two_of_five_digit: combinational, in [4:0] -> out [3:0] value, ok flag.
//    Two instances: tens and units.
//  Top: RR arbiter, stage-1 regs, stage-2 regs, error counter.
// TESTING
//  1) req0 only, addr=12'b01_11000_01010 -> gnt=0001 at N; o_valid at N+1, o_bin=147, o_src=0, o_err=0.
//  2) addr=12'b11_00101_00101 -> o_bin=399.
//     addr=12'b00_00011_00011 -> o_bin=0. Both o_err=0.
//  3) i_req=1111 held, i_rdy=1 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; o_src 0,1,2,3,0.
//  4) tens=11100 -> o_err=1, o_bin=0, o_err_cnt +1.
//     300 bad accepted results -> o_err_cnt=255.
//  5) i_rdy=0 for 5 cycles with 1111 pending -> one more grant fills s1, then no grants; outputs stable.
//     Release -> results resume in RR order, none lost or duplicated.
//  6) i_rst_n low during stall -> all outputs 0 asynchronously.
//     After release, first grant goes to the lowest pending request.

Source files
------------

// File: rtl/addr_dec_sched_pkg.sv
// Shared constants for the 2-of-5 address decoder scheduler.
// Address layout: [11:10] hundreds (binary), [9:5] tens a..e, [4:0] units a..e.
// Digit codes: bit 4 is segment a, bit 0 is segment e.
package addr_dec_pkg;
    localparam int ADDR_W = 12;
    localparam int BIN_W  = 9;
    localparam int H_LSB  = 10;
    localparam int T_LSB  = 5;
    localparam int U_LSB  = 0;

    localparam logic [4:0] CODE_0 = 5'b00011;  // de
    localparam logic [4:0] CODE_1 = 5'b10010;  // ad
    localparam logic [4:0] CODE_2 = 5'b10001;  // ae
    localparam logic [4:0] CODE_3 = 5'b01001;  // be
    localparam logic [4:0] CODE_4 = 5'b11000;  // ab
    localparam logic [4:0] CODE_5 = 5'b10100;  // ac
    localparam logic [4:0] CODE_6 = 5'b01100;  // bc
    localparam logic [4:0] CODE_7 = 5'b01010;  // bd
    localparam logic [4:0] CODE_8 = 5'b00110;  // cd
    localparam logic [4:0] CODE_9 = 5'b00101;  // ce

    localparam logic [BIN_W-1:0] HUND_WT = 9'd100;
    localparam logic [BIN_W-1:0] TENS_WT = 9'd10;
endpackage

// File: rtl/addr_dec_sched_if.sv
// Request/grant and result bus of the shared address decoder.
//   i_req/i_addr/o_gnt : requester side, level request, one-hot grant pulse
//   o_valid/i_rdy      : downstream result handshake
//   o_bin/o_src/o_err  : decoded address, requester index, malformed-code flag
//   o_err_cnt          : saturating count of accepted malformed results
// master = requesters/downstream side, slave = decoder.
interface addr_dec_sched_if #(
    parameter int NREQ = 4,
    parameter int SRCW = $clog2(NREQ)
);
    logic [NREQ-1:0]                     i_req;
    logic [addr_dec_pkg::ADDR_W*NREQ-1:0] i_addr;
    logic [NREQ-1:0]                     o_gnt;
    logic                                o_valid;
    logic                                i_rdy;
    logic [addr_dec_pkg::BIN_W-1:0]      o_bin;
    logic [SRCW-1:0]                     o_src;
    logic                                o_err;
    logic [7:0]                          o_err_cnt;

    modport master (
        output i_req, i_addr, i_rdy,
        input  o_gnt, o_valid, o_bin, o_src, o_err, o_err_cnt
    );

    modport slave (
        input  i_req, i_addr, i_rdy,
        output o_gnt, o_valid, o_bin, o_src, o_err, o_err_cnt
    );
endinterface

// File: rtl/addr_dec_sched_two_of_five_digit.sv
// Combinational 2-of-5 digit decoder.
//   code  in  [4:0]  segments a..e (bit 4 = a)
//   value out [3:0]  decimal digit, 0 when code is illegal
//   ok    out        code has exactly two bits set
module two_of_five_digit
    import addr_dec_pkg::*;
(
    input  logic [4:0] code,
    output logic [3:0] value,
    output logic       ok
);
    // All ten 2-bit patterns are listed, so default covers 0, 1 and 3+ bits set.
    always_comb begin
        value = 4'd0;
        ok    = 1'b1;
        case (code)
            CODE_0:  value = 4'd0;
            CODE_1:  value = 4'd1;
            CODE_2:  value = 4'd2;
            CODE_3:  value = 4'd3;
            CODE_4:  value = 4'd4;
            CODE_5:  value = 4'd5;
            CODE_6:  value = 4'd6;
            CODE_7:  value = 4'd7;
            CODE_8:  value = 4'd8;
            CODE_9:  value = 4'd9;
            default: ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/addr_dec_sched.sv
// Shared registered 2-of-5 address decoder with round-robin request arbitration.
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   bus      : slave side of addr_dec_sched_if (requests, grants, result handshake)
// Pipeline: arbitration loads stage 1 and a registered grant pulse together, so the
// grant is seen in the same cycle the slice sits in stage 1; stage 2 holds the result.
module addr_dec_sched
    import addr_dec_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int SRCW = $clog2(NREQ)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    addr_dec_sched_if.slave bus
);
    logic [SRCW-1:0]   last_q;
    logic [SRCW-1:0]   win_idx;
    logic              win_any;
    logic [ADDR_W-1:0] win_addr;
    logic [NREQ-1:0]   gnt_d;
    logic [NREQ-1:0]   gnt_q;

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [SRCW-1:0]   s1_src;
    logic              s1_adv;
    logic              grant_en;

    logic              out_valid;
    logic [BIN_W-1:0]  out_bin;
    logic [SRCW-1:0]   out_src;
    logic              out_err;
    logic [7:0]        err_cnt;
    logic              accept;

    logic [3:0]        tens_val;
    logic [3:0]        units_val;
    logic              tens_ok;
    logic              units_ok;
    logic              dec_err;
    logic [BIN_W-1:0]  dec_bin;

    assign accept   = out_valid & bus.i_rdy;
    assign s1_adv   = s1_valid & (~out_valid | bus.i_rdy);
    assign grant_en = ~s1_valid | s1_adv;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        logic [SRCW-1:0] cand;
        cand    = '0;
        win_any = 1'b0;
        win_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = SRCW'((int'(last_q) + i) % NREQ);
            if (!win_any && bus.i_req[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        gnt_d    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (SRCW'(k) == win_idx) begin
                win_addr = bus.i_addr[k*ADDR_W +: ADDR_W];
                gnt_d[k] = win_any & grant_en;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q   <= SRCW'(NREQ - 1);
            gnt_q    <= '0;
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_src   <= '0;
        end else begin
            gnt_q <= gnt_d;
            if (grant_en) begin
                s1_valid <= win_any;
                if (win_any) begin
                    s1_addr <= win_addr;
                    s1_src  <= win_idx;
                    last_q  <= win_idx;
                end
            end
        end
    end

    two_of_five_digit u_tens (
        .code  (s1_addr[T_LSB +: 5]),
        .value (tens_val),
        .ok    (tens_ok)
    );

    two_of_five_digit u_units (
        .code  (s1_addr[U_LSB +: 5]),
        .value (units_val),
        .ok    (units_ok)
    );

    assign dec_err = ~(tens_ok & units_ok);
    assign dec_bin = dec_err ? '0
                   : BIN_W'(s1_addr[H_LSB +: 2]) * HUND_WT
                   + BIN_W'(tens_val) * TENS_WT
                   + BIN_W'(units_val);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_src   <= '0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (s1_adv) begin
                out_valid <= 1'b1;
                out_bin   <= dec_bin;
                out_src   <= s1_src;
                out_err   <= dec_err;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (accept && out_err && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign bus.o_gnt     = gnt_q;
    assign bus.o_valid   = out_valid;
    assign bus.o_bin     = out_bin;
    assign bus.o_src     = out_src;
    assign bus.o_err     = out_err;
    assign bus.o_err_cnt = err_cnt;
endmodule

// File: tb/tb_addr_dec_sched.sv
// Bench for addr_dec_sched: directed scenarios plus a randomized phase, with a
// queue-based scoreboard fed by an arbitration model and drained by an output monitor.
module tb_addr_dec_sched;
    import addr_dec_pkg::*;

    localparam int NREQ = 4;
    localparam int SRCW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addr_dec_sched_if #(.NREQ(NREQ), .SRCW(SRCW)) bus ();

    addr_dec_sched #(.NREQ(NREQ), .SRCW(SRCW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int bin;
        int src;
        int err;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_acc = 0;
    int   m_last = NREQ - 1;
    int   m_errcnt = 0;

    logic [4:0]      codes [10] = '{5'b00011, 5'b10010, 5'b10001, 5'b01001, 5'b11000,
                                    5'b10100, 5'b01100, 5'b01010, 5'b00110, 5'b00101};
    logic [NREQ-1:0] pend = '0;
    logic [11:0]     req_addr [NREQ];
    logic            hold_mode = 1'b0;
    logic            rand_mode = 1'b0;
    logic            bad_mode  = 1'b0;
    logic            rdy_cmd   = 1'b1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int digit_of(input logic [4:0] c);
        for (int v = 0; v < 10; v++) if (codes[v] == c) return v;
        return -1;
    endfunction

    function automatic exp_t model(input logic [11:0] a, input int k);
        exp_t e;
        int h, t, u;
        h = int'(a[11:10]);
        t = digit_of(a[9:5]);
        u = digit_of(a[4:0]);
        e.src = k;
        if (t < 0 || u < 0) begin
            e.err = 1;
            e.bin = 0;
        end else begin
            e.err = 0;
            e.bin = h * 100 + t * 10 + u;
        end
        return e;
    endfunction

    function automatic logic [11:0] rand_addr();
        logic [4:0] bad;
        logic [1:0] h;
        h = 2'($urandom_range(0, 3));
        if (bad_mode) begin
            do bad = 5'($urandom_range(0, 31)); while ($countones(bad) == 2);
            return {h, bad, codes[$urandom_range(0, 9)]};
        end
        if ($urandom_range(0, 1) == 0) return 12'($urandom);
        return {h, codes[$urandom_range(0, 9)], codes[$urandom_range(0, 9)]};
    endfunction

    // Requester/downstream driver: sole writer of the bench-side bus signals.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                if (bus.o_gnt[k]) begin
                    if (hold_mode) req_addr[k] = rand_addr();
                    else pend[k] = 1'b0;
                end
            end
        end
        if (rand_mode) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k]     = 1'b1;
                    req_addr[k] = rand_addr();
                end
            end
            bus.i_rdy = ($urandom_range(0, 3) != 0);
        end else begin
            bus.i_rdy = rdy_cmd;
        end
        bus.i_req = pend;
        for (int k = 0; k < NREQ; k++) bus.i_addr[k*12 +: 12] = req_addr[k];
    end

    // Arbitration model: decides the rightful winner from the requests present at the
    // capturing edge and pushes the expected result for that requester.
    logic [NREQ-1:0] req_snap = '0;
    logic [11:0]     addr_snap [NREQ];
    always @(negedge clk) begin
        int exp_k;
        int c;
        if (rst_n && bus.o_gnt != '0) begin
            exp_k = -1;
            for (int i = 1; i <= NREQ; i++) begin
                c = (m_last + i) % NREQ;
                if (exp_k < 0 && req_snap[c]) exp_k = c;
            end
            chk("gnt_rr", int'(bus.o_gnt), (exp_k < 0) ? 0 : (1 << exp_k));
            if (exp_k >= 0) begin
                sb_q.push_back(model(addr_snap[exp_k], exp_k));
                m_last = exp_k;
            end
        end
        req_snap = bus.i_req;
        for (int k = 0; k < NREQ; k++) addr_snap[k] = bus.i_addr[k*12 +: 12];
    end

    // Output monitor: every accepted result must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.o_valid && bus.i_rdy) begin
            chk("err_cnt", int'(bus.o_err_cnt), m_errcnt);
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: result src %0d bin %0d with no expected entry",
                         bus.o_src, bus.o_bin);
            end else begin
                e = sb_q.pop_front();
                chk("bin", int'(bus.o_bin), e.bin);
                chk("src", int'(bus.o_src), e.src);
                chk("err", int'(bus.o_err), e.err);
                if (e.err != 0 && m_errcnt < 255) m_errcnt++;
            end
            n_acc++;
        end
    end

    task automatic issue(input int k, input logic [11:0] a);
        @(posedge clk);
        #2;
        pend[k]     = 1'b1;
        req_addr[k] = a;
    endtask

    task automatic wait_gnt(output logic [NREQ-1:0] g);
        g = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.o_gnt != '0) begin
                g = bus.o_gnt;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_gnt: no grant within 50 cycles");
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.o_valid) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_valid: no result within 50 cycles");
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pend == '0 && sb_q.size() == 0 && !bus.o_valid) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL drain: pipeline not empty after 400 cycles, %0d expected left", sb_q.size());
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] g;
        logic [11:0]     a;
        logic [8:0]      s_bin;
        logic [1:0]      s_src;
        int              mbefore;
        int              start;

        for (int k = 0; k < NREQ; k++) req_addr[k] = '0;
        bus.i_req  = '0;
        bus.i_addr = '0;
        bus.i_rdy  = 1'b1;
        #1;
        chk("rst_gnt",   int'(bus.o_gnt), 0);
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_bin",   int'(bus.o_bin), 0);
        chk("rst_src",   int'(bus.o_src), 0);
        chk("rst_err",   int'(bus.o_err), 0);
        chk("rst_cnt",   int'(bus.o_err_cnt), 0);
        #22;
        rst_n = 1'b1;

        // Single request, latency and decode of 147.
        issue(0, 12'b01_11000_01010);
        wait_gnt(g);
        chk("t1_gnt", int'(g), 1);
        chk("t1_idle", int'(bus.o_valid), 0);
        @(negedge clk);
        chk("t1_valid", int'(bus.o_valid), 1);
        chk("t1_bin", int'(bus.o_bin), 147);
        chk("t1_src", int'(bus.o_src), 0);
        chk("t1_err", int'(bus.o_err), 0);
        drain();

        // Decode extremes 399 and 0.
        issue(3, 12'b11_00101_00101);
        wait_valid();
        chk("t2_max", int'(bus.o_bin), 399);
        chk("t2_max_err", int'(bus.o_err), 0);
        drain();
        issue(3, 12'b00_00011_00011);
        wait_valid();
        chk("t2_zero", int'(bus.o_bin), 0);
        chk("t2_zero_err", int'(bus.o_err), 0);
        drain();

        // All requesters held: one grant per cycle in round-robin order.
        @(posedge clk);
        #2;
        for (int k = 0; k < NREQ; k++) req_addr[k] = rand_addr();
        hold_mode = 1'b1;
        pend      = '1;
        wait_gnt(g);
        chk("t3_g0", int'(g), 1);
        @(negedge clk); chk("t3_g1", int'(bus.o_gnt), 2);
        @(negedge clk); chk("t3_g2", int'(bus.o_gnt), 4);
        @(negedge clk); chk("t3_g3", int'(bus.o_gnt), 8);
        @(negedge clk); chk("t3_g4", int'(bus.o_gnt), 1);
        @(posedge clk);
        #2;
        hold_mode = 1'b0;
        drain();

        // One malformed tens digit.
        mbefore = m_errcnt;
        a = {2'b01, 5'b11100, codes[3]};
        issue(2, a);
        wait_valid();
        chk("t4_err", int'(bus.o_err), 1);
        chk("t4_bin", int'(bus.o_bin), 0);
        @(negedge clk);
        chk("t4_cnt", int'(bus.o_err_cnt), (mbefore < 255) ? mbefore + 1 : 255);
        drain();

        // 300 malformed results saturate the counter.
        start = n_acc;
        @(posedge clk);
        #2;
        bad_mode  = 1'b1;
        for (int k = 0; k < NREQ; k++) req_addr[k] = rand_addr();
        hold_mode = 1'b1;
        pend      = '1;
        for (int i = 0; i < 800 && (n_acc - start) < 300; i++) @(posedge clk);
        #2;
        chk("t4_count300", int'((n_acc - start) >= 300), 1);
        hold_mode = 1'b0;
        drain();
        bad_mode = 1'b0;
        chk("t4_sat", int'(bus.o_err_cnt), 255);

        // Stall with all requesters pending: no grants, outputs frozen.
        @(posedge clk);
        #2;
        for (int k = 0; k < NREQ; k++) req_addr[k] = rand_addr();
        hold_mode = 1'b1;
        pend      = '1;
        run_cycles(10);
        rdy_cmd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        s_bin = bus.o_bin;
        s_src = bus.o_src;
        chk("t5_valid", int'(bus.o_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_nogrant", int'(bus.o_gnt), 0);
            chk("t5_hold_valid", int'(bus.o_valid), 1);
            chk("t5_hold_bin", int'(bus.o_bin), int'(s_bin));
            chk("t5_hold_src", int'(bus.o_src), int'(s_src));
        end
        @(posedge clk);
        #2;
        rdy_cmd = 1'b1;
        run_cycles(10);
        rdy_cmd = 1'b0;
        run_cycles(4);

        // Asynchronous reset in the middle of a stall.
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_gnt",   int'(bus.o_gnt), 0);
        chk("t6_valid", int'(bus.o_valid), 0);
        chk("t6_bin",   int'(bus.o_bin), 0);
        chk("t6_src",   int'(bus.o_src), 0);
        chk("t6_err",   int'(bus.o_err), 0);
        chk("t6_cnt",   int'(bus.o_err_cnt), 0);
        sb_q.delete();
        m_last    = NREQ - 1;
        m_errcnt  = 0;
        hold_mode = 1'b0;
        pend      = 4'b1010;
        rdy_cmd   = 1'b1;
        run_cycles(2);
        #1;
        rst_n = 1'b1;
        wait_gnt(g);
        chk("t6_first", int'(g), 2);
        drain();

        // Randomized traffic with random back-pressure.
        @(posedge clk);
        #2;
        rand_mode = 1'b1;
        run_cycles(400);
        rand_mode = 1'b0;
        rdy_cmd   = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
